// File: rtl/spm_dma.sv
// Block-copy / block-fill engine that drives the scratchpad MEM port while busy.
// Copy takes three cycles per word (read, latch, write); fill writes one word per cycle.
module spm_dma #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    typedef enum logic [2:0] {IDLE, RD, LATCH, WR, DONE} state_t;

    state_t            state;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] data_q;

    logic [LEN_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0] idx_a;
    logic [ADDR_W-1:0] idx_nxt_a;

    assign idx_nxt   = idx + LEN_W'(1);
    assign idx_a     = idx[ADDR_W-1:0];
    assign idx_nxt_a = idx_nxt[ADDR_W-1:0];

    // Write data is a pure decode of latched registers, so it never follows inputs.
    assign spm_wr_data = mode_q ? fill_q : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            spm_as_  <= 1'b1;
            spm_rw   <= 1'b1;
            spm_addr <= '0;
            mode_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            fill_q   <= '0;
            data_q   <= '0;
        end else if (abort && state != IDLE) begin
            // A write strobed this cycle is still sampled by the SPM at this edge.
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            spm_as_ <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= len;
                        fill_q <= fill_data;
                        idx    <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (mode) begin
                            state    <= WR;
                            busy     <= 1'b1;
                            spm_as_  <= 1'b0;
                            spm_rw   <= 1'b0;
                            spm_addr <= dst_addr;
                        end else begin
                            state    <= RD;
                            busy     <= 1'b1;
                            spm_as_  <= 1'b0;
                            spm_rw   <= 1'b1;
                            spm_addr <= src_addr;
                        end
                    end
                end
                RD: begin
                    state   <= LATCH;
                    spm_as_ <= 1'b1;
                end
                LATCH: begin
                    state    <= WR;
                    data_q   <= spm_rd_data;
                    spm_as_  <= 1'b0;
                    spm_rw   <= 1'b0;
                    spm_addr <= dst_q + idx_a;
                end
                WR: begin
                    idx <= idx_nxt;
                    if (idx_nxt == len_q) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        spm_as_ <= 1'b1;
                    end else if (mode_q) begin
                        spm_addr <= dst_q + idx_nxt_a;
                    end else begin
                        state    <= RD;
                        spm_rw   <= 1'b1;
                        spm_addr <= src_q + idx_nxt_a;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    spm_as_ <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_dma.sv
// Self-checking bench for spm_dma: an SPM model, a strobe scoreboard fed by a
// reference copy/fill model, done-cycle timing and memory readback checks.
module tb_spm_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [12:0] len;
    logic [31:0] fill_data;
    logic        abort;
    logic        busy;
    logic        done;
    logic [11:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        rw;
        logic [11:0] addr;
        logic [31:0] data;
    } strobe_t;

    strobe_t     sb[$];
    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];

    spm_dma dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SPM model: read data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (spm_as_ === 1'b0) begin
            if (spm_rw) spm_rd_data <= mem[spm_addr];
            else        mem[spm_addr] = spm_wr_data;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && spm_as_ === 1'b0) begin
            chk("strobe_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                strobe_t e;
                e = sb.pop_front();
                chk("strobe_rw", spm_rw, e.rw);
                chk("strobe_addr", spm_addr, e.addr);
                if (!e.rw) chk("strobe_wdata", spm_wr_data, e.data);
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Reference model: push expected strobes and update ref_mem in ascending order.
    task automatic model(input logic m, input logic [11:0] s, input logic [11:0] d,
                         input logic [31:0] f, input int words);
        for (int i = 0; i < words; i++) begin
            logic [11:0] sa, da;
            logic [31:0] v;
            strobe_t     e;
            sa = s + 12'(i);
            da = d + 12'(i);
            if (m) v = f;
            else begin
                v = ref_mem[sa];
                e = '{rw: 1'b1, addr: sa, data: 32'h0};
                sb.push_back(e);
            end
            e = '{rw: 1'b0, addr: da, data: v};
            sb.push_back(e);
            ref_mem[da] = v;
        end
    endtask

    task automatic run_xfer(input string name, input logic m, input logic [11:0] s,
                            input logic [11:0] d, input int n, input logic [31:0] f,
                            input int model_words, input int abort_at, input bit poke);
        int exp_done, done_at, budget;
        bit got_done;
        exp_done = m ? n + 1 : 3 * n + 1;
        if (n == 0) exp_done = 1;
        budget   = (abort_at > 0) ? abort_at + 5 : exp_done + 10;
        got_done = 0;
        done_at  = 0;
        model(m, s, d, f, model_words);
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = 13'(n); fill_data = f;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1 && n != 0) chk({name, "_busy_c1"}, busy, 1);
            if (done && !got_done) begin
                got_done = 1;
                done_at  = c;
                chk({name, "_busy_at_done"}, busy, 0);
            end
            if (poke && c == 2) begin
                start = 1'b1; mode = 1'b0; src_addr = 12'h7A0; dst_addr = 12'h300; len = 13'd1;
            end
            if (poke && c == 3) start = 1'b0;
            if (abort_at > 0 && c == abort_at) abort = 1'b1;
            if (abort_at > 0 && c == abort_at + 1) begin
                abort = 1'b0;
                chk({name, "_busy_after_abort"}, busy, 0);
            end
            if (abort_at == 0 && got_done) break;
        end
        if (abort_at > 0) chk({name, "_no_done"}, 64'(got_done), 0);
        else              chk({name, "_done_cycle"}, done_at, exp_done);
        chk({name, "_sb_drained"}, sb.size(), 0);
        for (int i = 0; i <= model_words; i++) begin
            logic [11:0] da;
            da = d + 12'(i);
            chk({name, "_mem"}, mem[da], ref_mem[da]);
        end
        sb.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; abort = 1'b0; spm_rd_data = '0;
        for (int i = 0; i < 4096; i++) preload(12'(i), 32'h5A00_0000 + 32'(i * 7));
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_as", spm_as_, 1);
        chk("rst_rw", spm_rw, 1);
        chk("rst_addr", spm_addr, 0);
        chk("rst_wdata", spm_wr_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_xfer("fill", 1'b1, 12'h000, 12'h010, 4, 32'hDEADBEEF, 4, 0, 1'b0);

        preload(12'h100, 32'd1); preload(12'h101, 32'd2); preload(12'h102, 32'd3);
        run_xfer("copy", 1'b0, 12'h100, 12'h200, 3, 32'h0, 3, 0, 1'b0);
        chk("copy_w202", mem[12'h202], 32'd3);

        run_xfer("wrap", 1'b1, 12'h000, 12'hFFE, 4, 32'h1234_5678, 4, 0, 1'b0);
        chk("wrap_w001", mem[12'h001], 32'h1234_5678);

        preload(12'h020, 32'hAAAA_0001); preload(12'h021, 32'hBBBB_0002);
        run_xfer("overlap", 1'b0, 12'h020, 12'h021, 2, 32'h0, 2, 0, 1'b0);
        chk("overlap_w022", mem[12'h022], 32'hAAAA_0001);

        // WR of idx=2 is cycle 9 after the start edge
        run_xfer("abort", 1'b0, 12'h400, 12'h500, 8, 32'h0, 3, 9, 1'b0);

        run_xfer("len0", 1'b1, 12'h000, 12'h600, 0, 32'hFFFF_FFFF, 0, 0, 1'b0);

        run_xfer("busy_start", 1'b1, 12'h000, 12'h700, 5, 32'hCAFE_F00D, 5, 0, 1'b1);
        chk("busy_start_untouched", mem[12'h300], ref_mem[12'h300]);

        begin
            strobe_t e;
            logic [31:0] old;
            old = mem[12'h900];
            e = '{rw: 1'b1, addr: 12'h800, data: 32'h0};
            sb.push_back(e);
            @(negedge clk);
            start = 1'b1; mode = 1'b0; src_addr = 12'h800; dst_addr = 12'h900; len = 13'd2;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            chk("rstmid_busy", busy, 0);
            chk("rstmid_as", spm_as_, 1);
            chk("rstmid_rw", spm_rw, 1);
            chk("rstmid_addr", spm_addr, 0);
            chk("rstmid_wdata", spm_wr_data, 0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);
            chk("rstmid_no_write", mem[12'h900], old);
            chk("rstmid_sb_drained", sb.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spm_dma.md
# spm_dma

Block-copy / block-fill engine that initiates accesses on the data-side (MEM) port of the scratchpad memory. A single start pulse moves a run of 32-bit words from one SPM region to another, or fills a region with a constant, without CPU load/store traffic. It sits beside the MEM stage and owns the SPM MEM port while `busy` is high; the CPU-side arbiter muxes it in.

## Interface
- `ADDR_W`, 12, SPM word-address width; all address arithmetic is modulo 2^ADDR_W.
- `DATA_W`, 32, SPM data width.
- `LEN_W`, 13, width of word count; 0..4096.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; sampled with `start`.
- `src_addr`  in  ADDR_W  copy source base; sampled with `start`.
- `dst_addr`  in  ADDR_W  destination base; sampled with `start`.
- `len`  in  LEN_W  word count; sampled with `start`.
- `fill_data`  in  DATA_W  fill word; sampled with `start`.
- `abort`  in  1  stop the transfer; honoured in any non-IDLE state.
- `busy`  out  1  high from the cycle after an accepted start until the done cycle.
- `done`  out  1  one-cycle pulse on normal completion.
- `spm_addr`  out  ADDR_W  to SPM MEM port address.
- `spm_as_`  out  1  address strobe, active low.
- `spm_rw`  out  1  1 = read, 0 = write.
- `spm_wr_data`  out  DATA_W  to SPM MEM port write data.
- `spm_rd_data`  in  DATA_W  from SPM MEM port; valid the cycle after a read strobe.

## Operation
- States: IDLE, RD, LATCH, WR, DONE.
- IDLE: `start`=1 captures `mode`, `src_addr`, `dst_addr`, `len`, `fill_data`; clears word index `idx`.
  - `len`=0 -> DONE.
  - else copy -> RD, fill -> WR.
- RD: `spm_as_`=0, `spm_rw`=1, `spm_addr`=src+idx -> LATCH.
- LATCH: `spm_as_`=1; `spm_rd_data` captured into `data_q` at the edge -> WR.
- WR: `spm_as_`=0, `spm_rw`=0, `spm_addr`=dst+idx, `spm_wr_data`=`data_q` (copy) or captured fill word (fill); `idx`++.
  - idx+1 == len -> DONE.
  - else copy -> RD, fill -> WR.
- DONE: `done`=1, `busy`=0, strobe idle -> IDLE.
- `abort`=1 in RD/LATCH/WR/DONE -> IDLE at next edge.
  - No `done` pulse unless already in DONE.
  - A write strobed in the abort cycle still completes, since the SPM samples it at that edge.
- `start` outside IDLE is ignored; the latched parameters never change mid-transfer.
- Address wrap: src+idx and dst+idx truncate to ADDR_W bits (0xFFF+1 -> 0x000).
- Copy order is strictly ascending. With overlapping regions and dst > src, already-written words are re-read, which gives a replicating pattern. This is required behaviour, not an error.
- `spm_*` outputs are a Moore decode of registered state, with no combinational path from inputs.

## Timing
- Reset values:
  - state=IDLE
  - `busy`=0, `done`=0
  - `spm_as_`=1, `spm_rw`=1
  - `spm_addr`=0, `spm_wr_data`=0
  - `idx`=0, `data_q`=0
- `reset` mid-transfer returns to IDLE immediately; the pending word is not written.
- Copy: 3 cycles per word; `done` in cycle 3·len+1 after the start edge.
- Fill: 1 cycle per word; `done` in cycle len+1.
- `len`=0: `done` in cycle 1, no strobe.
- `busy` is high in RD/LATCH/WR and low in IDLE/DONE.
- A new `start` is accepted in the cycle after `done`.
- Idle cycles keep `spm_as_`=1; `spm_addr` and `spm_rw` are don't-care but must hold stable.

## Test plan
- Fill: start mode=1, dst=0x010, len=4, fill=0xDEADBEEF.
  - Expect 4 consecutive write strobes at 0x010..0x013.
  - `done` at cycle 5; SPM words read back as 0xDEADBEEF.
- Copy: preload 0x100..0x102 = 1, 2, 3; start mode=0, src=0x100, dst=0x200, len=3.
  - Expect strobe sequence R100, W200, R101, W201, R102, W202.
  - `done` at cycle 10; 0x200..0x202 = 1, 2, 3.
- Wrap: fill dst=0xFFE, len=4.
  - Expect writes at 0xFFE, 0xFFF, 0x000, 0x001.
- Overlap: preload 0x020=A, 0x021=B; copy src=0x020, dst=0x021, len=2.
  - Expect 0x021=A, 0x022=A.
- Abort: copy len=8; assert `abort` in the WR state of word 2 (idx=2).
  - Words 0..2 written, no further strobes, no `done`, `busy`=0 next cycle.
- Corners:
  - `len`=0 -> `done` at cycle 1, no strobe.
  - `start` while busy -> ignored.
  - `reset` during LATCH -> all outputs at reset values immediately, no write issued.
